// File: rtl/div_pkg.sv
// Shared types and constants for the pipelined divide front end.
//   DIV_W     : operand width of the wrapped combinational divider
//   DIV_TAG_W : width of the opaque request tag
//   div_s1_t  : stage-1 payload (magnitudes, original dividend, sign/special flags, tag)
//   div_res_t : stage-2 payload (corrected quotient/remainder, flags, tag)
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_TAG_W = 4;

  localparam logic [DIV_W-1:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic [DIV_W-1:0]     mag_a;
    logic [DIV_W-1:0]     mag_b;
    logic [DIV_W-1:0]     orig_a;
    logic                 sign_q;
    logic                 sign_r;
    logic                 dbz;
    logic                 ovf;
    logic [DIV_TAG_W-1:0] tag;
  } div_s1_t;

  typedef struct packed {
    logic [DIV_W-1:0]     q;
    logic [DIV_W-1:0]     r;
    logic                 dbz;
    logic                 ovf;
    logic [DIV_TAG_W-1:0] tag;
  } div_res_t;

  // Two's-complement negate when neg is set. INT_MIN maps onto itself,
  // which is exactly its magnitude when read as unsigned.
  function automatic logic [DIV_W-1:0] cond_neg(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_pipe_reg.sv
// One valid/ready register slice carrying a payload of type T.
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and registered payload
// in_ready is combinational from out_ready, so chained slices keep one
// transfer per cycle without a skid buffer.
module div_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q,  data_d;

  // NOTE: every variable is given a default at the top of the block, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    // Payload only moves on a real transfer, so a stalled or idle slice
    // keeps presenting its last value.
    if (in_ready && in_valid) begin
      data_d = in_data;
    end
  end

  // NOTE: the payload register is reset too, so outputs read as zero
  // rather than X after reset even though they are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/divider_32_unsign.sv
// Combinational 32-bit unsigned divider core.
//   a, b : dividend, divisor (unsigned)
//   q, r : quotient, remainder; for b == 0 returns q = all ones, r = a
module divider_32_unsign (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r
);

  always_comb begin
    q = '1;
    r = a;
    if (b != '0) begin
      q = a / b;
      r = a % b;
    end
  end

endmodule

// File: rtl/divider_32_pipe_front.sv
// Two-stage valid/ready signed/unsigned divide unit around divider_32_unsign.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : request handshake
//   in_signed, in_a, in_b, in_tag : request (signed mode, dividend, divisor, tag)
//   out_valid/out_ready           : result handshake
//   out_q, out_r                  : quotient, remainder (truncated toward zero)
//   out_dbz, out_ovf              : divide-by-zero, signed INT_MIN / -1
//   out_tag                       : tag of this result
// Stage 1 registers magnitudes and special-case flags; the unsigned core
// sits between the stages; stage 2 registers the sign-corrected result.
module divider_32_pipe_front
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  // The core divider and the payload structs are fixed-width.
  if (WIDTH != DIV_W) begin : g_width_check
    $error("divider_32_pipe_front: WIDTH must be 32");
  end
  if (TAG_W != DIV_TAG_W) begin : g_tag_check
    $error("divider_32_pipe_front: TAG_W must match div_pkg::DIV_TAG_W");
  end

  div_s1_t  s1_in, s1_out;
  div_res_t s2_in, s2_out;
  logic     s1_valid, s2_ready;
  logic     sign_a, sign_b;
  logic [DIV_W-1:0] uq, ur;

  // Stage 1 input: magnitudes and special cases from the raw operands.
  always_comb begin
    sign_a        = in_signed && in_a[DIV_W-1];
    sign_b        = in_signed && in_b[DIV_W-1];
    s1_in         = '0;
    s1_in.mag_a   = cond_neg(sign_a, in_a);
    s1_in.mag_b   = cond_neg(sign_b, in_b);
    s1_in.orig_a  = in_a;
    s1_in.sign_q  = sign_a ^ sign_b;
    s1_in.sign_r  = sign_a;
    s1_in.dbz     = (in_b == '0);
    s1_in.ovf     = in_signed && (in_a == INT_MIN) && (in_b == '1);
    s1_in.tag     = in_tag;
  end

  div_pipe_reg #(.T(div_s1_t)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  divider_32_unsign u_core (
    .a (s1_out.mag_a),
    .b (s1_out.mag_b),
    .q (uq),
    .r (ur)
  );

  // Stage 2 input: special cases override the core; otherwise restore signs.
  // dbz and ovf are mutually exclusive (ovf needs b = -1).
  always_comb begin
    s2_in     = '0;
    s2_in.tag = s1_out.tag;
    if (s1_out.dbz) begin
      s2_in.q   = '1;
      s2_in.r   = s1_out.orig_a;
      s2_in.dbz = 1'b1;
    end else if (s1_out.ovf) begin
      s2_in.q   = INT_MIN;
      s2_in.r   = '0;
      s2_in.ovf = 1'b1;
    end else begin
      s2_in.q = cond_neg(s1_out.sign_q, uq);
      s2_in.r = cond_neg(s1_out.sign_r, ur);
    end
  end

  div_pipe_reg #(.T(div_res_t)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_q   = s2_out.q;
  assign out_r   = s2_out.r;
  assign out_dbz = s2_out.dbz;
  assign out_ovf = s2_out.ovf;
  assign out_tag = s2_out.tag;

endmodule
